ysyx_22041207_axi_rd_arbiter_n: RTL and testbench

N-requester read-channel arbiter, the parametrised successor of the two-port IF/MEM read switch. Multiplexes N read masters (IF, MEM, DMA, ...) onto one downstream read-slave interface using the same valid/ready address phase and data_valid/data_ready data phase. A registered grant and an explicit FSM hold the grant across the whole transaction. Priority is fixed or round-robin, selected at compile time.

---
 rtl/ysyx_22041207_arb_pkg.sv | 25 ++
 rtl/ysyx_22041207_rr_pick.sv | 28 ++
 rtl/ysyx_22041207_axi_rd_arbiter_n.sv | 139 +++++++++++++
 tb/tb_ysyx_22041207_axi_rd_arbiter_n.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_arb_pkg.sv
// Shared types for the N-master read arbiter: FSM encoding, size field type,
// and the one-hot to index helper.
package ysyx_22041207_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_e;

  typedef logic [7:0] arb_size_t;

  localparam int ARB_MAX_M = 32;

  // OR-reduction of set positions; exact for one-hot and zero inputs.
  function automatic logic [4:0] onehot2idx(input logic [ARB_MAX_M-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_M; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ysyx_22041207_rr_pick.sv
// Combinational priority picker: scans requests upward from i_start, wrapping,
// and returns a one-hot grant for the first set request (zero if none).
module ysyx_22041207_rr_pick #(
  parameter int NUM_M = 2,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [NUM_M-1:0] o_gnt
);

  always_comb begin
    int   j;
    logic found;
    o_gnt = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_M; k++) begin
      j = int'(i_start) + k;
      if (j >= NUM_M) j = j - NUM_M;
      if (!found && i_req[j]) begin
        o_gnt[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041207_axi_rd_arbiter_n.sv
// N-master read-channel arbiter with a registered grant held for a whole
// address+data transaction. ARB_ROUND_ROBIN_EN selects round-robin, else fixed highest-index priority.
module ysyx_22041207_axi_rd_arbiter_n
  import ysyx_22041207_arb_pkg::*;
#(
  parameter int NUM_M         = 2,
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 64,
  parameter int IDX_W         = $clog2(NUM_M)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_M-1:0]                 m_r_valid_i,
  output logic [NUM_M-1:0]                 m_r_ready_o,
  input  logic [NUM_M*RW_ADDR_WIDTH-1:0]   m_r_addr_i,
  input  logic [NUM_M*8-1:0]               m_r_size_i,
  output logic [NUM_M*RW_DATA_WIDTH-1:0]   m_data_read_o,
  output logic [NUM_M-1:0]                 m_r_data_valid_o,
  input  logic [NUM_M-1:0]                 m_r_data_ready_i,
  output logic                             s_r_valid_o,
  input  logic                             s_r_ready_i,
  output logic [RW_ADDR_WIDTH-1:0]         s_r_addr_o,
  output logic [7:0]                       s_r_size_o,
  input  logic [RW_DATA_WIDTH-1:0]         s_data_read_i,
  input  logic                             s_r_data_valid_i,
  output logic                             s_r_data_ready_o,
  output logic [NUM_M-1:0]                 grant_o,
  output logic                             busy_o
);

  // Handshakes: address beat when s_r_valid_o && s_r_ready_i, data beat when
  // s_r_data_valid_i && s_r_data_ready_o; both only for the granted master.
  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [NUM_M-1:0] r_grant;
  logic [NUM_M-1:0] w_pick;
  logic [IDX_W-1:0] w_idx;
  logic             w_st_idle, w_st_addr, w_st_data;
  logic             w_any, w_gv, w_gdr, w_d_hs;
  arb_size_t        w_size;

  assign w_st_idle = (r_state == ARB_IDLE);
  assign w_st_addr = (r_state == ARB_ADDR);
  assign w_st_data = (r_state == ARB_DATA);
  assign w_any     = |m_r_valid_i;
  assign w_idx     = IDX_W'(onehot2idx(ARB_MAX_M'(r_grant)));
  assign w_gv      = m_r_valid_i[w_idx];
  assign w_gdr     = m_r_data_ready_i[w_idx];
  assign w_d_hs    = w_st_data & s_r_data_valid_i & w_gdr;
  assign w_size    = m_r_size_i[int'(w_idx)*8 +: 8];

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  ysyx_22041207_rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
    .i_req   (m_r_valid_i),
    .i_start (r_rr_ptr),
    .o_gnt   (w_pick)
  );

  // Pointer advances only on data completion, so aborted requests keep their turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_d_hs) begin
      r_rr_ptr <= (w_idx == IDX_W'(NUM_M-1)) ? '0 : w_idx + 1'b1;
    end
  end
`else
  logic [NUM_M-1:0] w_req_rev;
  logic [NUM_M-1:0] w_pick_rev;

  // Bit-reversing around the picker with start 0 makes the highest index win.
  always_comb begin
    w_req_rev = '0;
    w_pick    = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_req_rev[i] = m_r_valid_i[NUM_M-1-i];
      w_pick[i]    = w_pick_rev[NUM_M-1-i];
    end
  end

  ysyx_22041207_rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
    .i_req   (w_req_rev),
    .i_start ({IDX_W{1'b0}}),
    .o_gnt   (w_pick_rev)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = ARB_IDLE;
    case (r_state)
      ARB_IDLE: w_next = w_any ? ARB_ADDR : ARB_IDLE;
      ARB_ADDR: begin
        if (!w_gv)            w_next = ARB_IDLE;
        else if (s_r_ready_i) w_next = ARB_DATA;
        else                  w_next = ARB_ADDR;
      end
      ARB_DATA: w_next = w_d_hs ? ARB_IDLE : ARB_DATA;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
    end else if (w_st_idle) begin
      r_grant <= w_pick;
    end else if (w_next == ARB_IDLE) begin
      r_grant <= '0;
    end
  end

  always_comb begin
    busy_o           = w_st_addr | w_st_data;
    grant_o          = (w_st_addr | w_st_data) ? r_grant : '0;
    s_r_valid_o      = w_st_addr & w_gv;
    s_r_addr_o       = w_st_addr ? m_r_addr_i[int'(w_idx)*RW_ADDR_WIDTH +: RW_ADDR_WIDTH] : '0;
    s_r_size_o       = w_st_addr ? w_size : '0;
    m_r_ready_o      = w_st_addr ? (r_grant & {NUM_M{s_r_ready_i}}) : '0;
    s_r_data_ready_o = w_st_data & w_gdr;
    m_r_data_valid_o = w_st_data ? (r_grant & {NUM_M{s_r_data_valid_i}}) : '0;
    m_data_read_o    = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_st_data && r_grant[i]) begin
        m_data_read_o[i*RW_DATA_WIDTH +: RW_DATA_WIDTH] = s_data_read_i;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_arbiter_n.sv
// Bench for the N-master read arbiter: per-cycle vector table on a 4-master
// instance, reset/abort sequences, and randomized isolation on a 3-master instance.
module tb_ysyx_22041207_axi_rd_arbiter_n;

  localparam int NM = 4;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam logic [DW-1:0] RDATA = 64'hDEAD_BEEF_0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-master instance
  logic [NM-1:0]    m_r_valid_i, m_r_ready_o, m_r_data_valid_o, m_r_data_ready_i, grant_o;
  logic [NM*AW-1:0] m_r_addr_i;
  logic [NM*8-1:0]  m_r_size_i;
  logic [NM*DW-1:0] m_data_read_o;
  logic             s_r_valid_o, s_r_ready_i, s_r_data_valid_i, s_r_data_ready_o, busy_o;
  logic [AW-1:0]    s_r_addr_o;
  logic [7:0]       s_r_size_o;
  logic [DW-1:0]    s_data_read_i;

  logic [AW-1:0] addr_tab [NM];
  logic [7:0]    size_tab [NM];

  assign m_r_addr_i    = {64'h3000_0080, 64'h8000_0010, 64'h2000_0040, 64'h1000_0000};
  assign m_r_size_i    = {8'd4, 8'd8, 8'd2, 8'd1};
  assign s_data_read_i = RDATA;

  ysyx_22041207_axi_rd_arbiter_n #(.NUM_M(NM), .RW_DATA_WIDTH(DW), .RW_ADDR_WIDTH(AW)) u_dut4 (
    .clk(clk), .rst(rst),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
    .m_r_addr_i(m_r_addr_i), .m_r_size_i(m_r_size_i),
    .m_data_read_o(m_data_read_o), .m_r_data_valid_o(m_r_data_valid_o),
    .m_r_data_ready_i(m_r_data_ready_i),
    .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i),
    .s_r_addr_o(s_r_addr_o), .s_r_size_o(s_r_size_o),
    .s_data_read_i(s_data_read_i), .s_r_data_valid_i(s_r_data_valid_i),
    .s_r_data_ready_o(s_r_data_ready_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  // 3-master instance
  logic [2:0]      t3_valid, t3_mrdy, t3_mdv, t3_mdr, t3_grant;
  logic [3*AW-1:0] t3_addr;
  logic [3*8-1:0]  t3_size;
  logic [3*DW-1:0] t3_mdata;
  logic            t3_sv, t3_sr, t3_sdv, t3_sdr, t3_busy;
  logic [AW-1:0]   t3_saddr;
  logic [7:0]      t3_ssize;
  logic [DW-1:0]   t3_sdata;

  assign t3_addr = {64'hC000_0300, 64'hB000_0200, 64'hA000_0100};
  assign t3_size = {8'd3, 8'd2, 8'd1};

  ysyx_22041207_axi_rd_arbiter_n #(.NUM_M(3), .RW_DATA_WIDTH(DW), .RW_ADDR_WIDTH(AW)) u_dut3 (
    .clk(clk), .rst(rst),
    .m_r_valid_i(t3_valid), .m_r_ready_o(t3_mrdy),
    .m_r_addr_i(t3_addr), .m_r_size_i(t3_size),
    .m_data_read_o(t3_mdata), .m_r_data_valid_o(t3_mdv),
    .m_r_data_ready_i(t3_mdr),
    .s_r_valid_o(t3_sv), .s_r_ready_i(t3_sr),
    .s_r_addr_o(t3_saddr), .s_r_size_o(t3_ssize),
    .s_data_read_i(t3_sdata), .s_r_data_valid_i(t3_sdv),
    .s_r_data_ready_o(t3_sdr), .grant_o(t3_grant), .busy_o(t3_busy)
  );

  typedef struct {
    logic [NM-1:0] v;
    logic          sr;
    logic          sdv;
    logic [NM-1:0] mdr;
    logic          e_busy;
    logic [NM-1:0] e_grant;
    logic [NM-1:0] e_mrdy;
    logic [NM-1:0] e_mdv;
    logic          e_sv;
    logic          e_sdr;
    int            e_aslot;
    int            e_dslot;
    string         name;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input logic [NM-1:0] v, input logic sr, input logic sdv, input logic [NM-1:0] mdr,
                      input logic eb, input logic [NM-1:0] eg, input logic [NM-1:0] emr,
                      input logic [NM-1:0] emd, input logic esv, input logic esdr,
                      input int ea, input int ed, input string nm);
    vec_t x;
    x.v = v; x.sr = sr; x.sdv = sdv; x.mdr = mdr;
    x.e_busy = eb; x.e_grant = eg; x.e_mrdy = emr; x.e_mdv = emd;
    x.e_sv = esv; x.e_sdr = esdr; x.e_aslot = ea; x.e_dslot = ed; x.name = nm;
    vecs.push_back(x);
  endtask

  task automatic add_idle(input logic [NM-1:0] v, input string nm);
    push(v, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, -1, -1, nm);
  endtask

  task automatic add_addr(input logic [NM-1:0] v, input logic sr, input int g, input string nm);
    logic [NM-1:0] gm;
    gm = NM'(1 << g);
    push(v, sr, 1'b0, '0, 1'b1, gm, sr ? gm : '0, '0, v[g], 1'b0, g, -1, nm);
  endtask

  task automatic add_data(input logic [NM-1:0] v, input logic sdv, input logic [NM-1:0] mdr,
                          input int g, input string nm);
    logic [NM-1:0] gm;
    gm = NM'(1 << g);
    push(v, 1'b0, sdv, mdr, 1'b1, gm, '0, sdv ? gm : '0, 1'b0, mdr[g], -1, g, nm);
  endtask

  task automatic run_vec(input vec_t x);
    logic [AW-1:0]    ea;
    logic [7:0]       es;
    logic [NM*DW-1:0] ed;
    logic             ok;
    @(negedge clk);
    m_r_valid_i = x.v; s_r_ready_i = x.sr; s_r_data_valid_i = x.sdv; m_r_data_ready_i = x.mdr;
    #1;
    ea = '0; es = '0; ed = '0;
    if (x.e_aslot >= 0) begin ea = addr_tab[x.e_aslot]; es = size_tab[x.e_aslot]; end
    if (x.e_dslot >= 0) ed[x.e_dslot*DW +: DW] = RDATA;
    ok = (busy_o === x.e_busy) && (grant_o === x.e_grant) && (m_r_ready_o === x.e_mrdy) &&
         (m_r_data_valid_o === x.e_mdv) && (s_r_valid_o === x.e_sv) &&
         (s_r_data_ready_o === x.e_sdr) && (s_r_addr_o === ea) && (s_r_size_o === es) &&
         (m_data_read_o === ed);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got busy=%b grant=%b mrdy=%b mdv=%b sv=%b sdr=%b addr=%h size=%h data_ok=%b; want busy=%b grant=%b mrdy=%b mdv=%b sv=%b sdr=%b addr=%h size=%h",
               x.name, busy_o, grant_o, m_r_ready_o, m_r_data_valid_o, s_r_valid_o, s_r_data_ready_o,
               s_r_addr_o, s_r_size_o, (m_data_read_o === ed), x.e_busy, x.e_grant, x.e_mrdy,
               x.e_mdv, x.e_sv, x.e_sdr, ea, es);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_all_zero(input string nm);
    logic ok;
    ok = (busy_o === 1'b0) && (grant_o === '0) && (m_r_ready_o === '0) && (m_r_data_valid_o === '0) &&
         (s_r_valid_o === 1'b0) && (s_r_data_ready_o === 1'b0) && (s_r_addr_o === '0) &&
         (s_r_size_o === '0) && (m_data_read_o === '0);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got busy=%b grant=%b mrdy=%b mdv=%b sv=%b sdr=%b; want all zero",
               nm, busy_o, grant_o, m_r_ready_o, m_r_data_valid_o, s_r_valid_o, s_r_data_ready_o);
    end
  endtask

  initial begin
    int            ord[3];
    int            pg;
    logic [NM-1:0] v;
    int            done_cnt;
    logic          ok;

    addr_tab = '{64'h1000_0000, 64'h2000_0040, 64'h8000_0010, 64'h3000_0080};
    size_tab = '{8'd1, 8'd2, 8'd8, 8'd4};

    // Reset held with every input active: outputs must all be zero.
    m_r_valid_i = '1; s_r_ready_i = 1'b1; s_r_data_valid_i = 1'b1; m_r_data_ready_i = '1;
    t3_valid = '0; t3_sr = 1'b0; t3_sdv = 1'b0; t3_mdr = '0; t3_sdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    m_r_valid_i = '0; s_r_ready_i = 1'b0; s_r_data_valid_i = 1'b0; m_r_data_ready_i = '0;
    rst = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 3};
    pg  = 0;
`else
    ord = '{3, 1, 0};
    pg  = 1;
`endif

    // Contention: masters 0,1,3 held until served.
    v = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      add_idle(v, "cont_idle");
      add_addr(v, 1'b1, ord[k], "cont_addr");
      v[ord[k]] = 1'b0;
      add_data(v, 1'b1, 4'b1111, ord[k], "cont_data");
    end
    add_idle(4'b0000, "cont_end");

    // Single request from master 2.
    add_idle(4'b0100, "single_req");
    add_addr(4'b0100, 1'b1, 2, "single_addr");
    add_data(4'b0000, 1'b1, 4'b0100, 2, "single_data");
    add_idle(4'b0000, "single_end");

    // Backpressure on both phases for master 1.
    add_idle(4'b0010, "bp_req");
    for (int k = 0; k < 5; k++) add_addr(4'b0010, 1'b0, 1, "bp_addr_wait");
    add_addr(4'b0010, 1'b1, 1, "bp_addr_hs");
    for (int k = 0; k < 3; k++) add_data(4'b0000, 1'b1, 4'b0000, 1, "bp_data_wait");
    add_data(4'b0000, 1'b1, 4'b0010, 1, "bp_data_hs");
    add_idle(4'b0000, "bp_end");

    // Abort: master 0 drops valid while downstream is ready.
    add_idle(4'b0001, "abort_req");
    add_addr(4'b0001, 1'b0, 0, "abort_addr");
    add_addr(4'b0000, 1'b1, 0, "abort_drop");
    add_idle(4'b0000, "abort_idle");

    // Probe: pointer after abort decides between masters 0 and 1.
    add_idle(4'b0011, "probe_req");
    add_addr(4'b0011, 1'b0, pg, "probe_grant");
    add_addr(4'b0000, 1'b0, pg, "probe_drop");
    add_idle(4'b0000, "probe_end");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a DATA phase for master 1.
    @(negedge clk);
    m_r_valid_i = 4'b0010;
    @(negedge clk);
    s_r_ready_i = 1'b1;
    @(negedge clk);
    m_r_valid_i = '0; s_r_ready_i = 1'b0;
    #1;
    check("rst_pre_data_busy", 32'(busy_o), 32'd1);
    check("rst_pre_data_grant", 32'(grant_o), 32'h2);
    @(negedge clk);
    s_r_data_valid_i = 1'b1; m_r_data_ready_i = 4'b0010; rst = 1'b1;
    #1;
    check_all_zero("rst_mid_data");
    @(negedge clk);
    s_r_data_valid_i = 1'b0; m_r_data_ready_i = '0; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_all_zero("rst_release_idle");
    end
    @(negedge clk);
    m_r_valid_i = 4'b0010;
    #1;
    check("rst_req_same_cycle", 32'(busy_o), 32'd0);
    @(negedge clk);
    #1;
    check("rst_req_granted", 32'(grant_o), 32'h2);
    m_r_valid_i = '0;
    @(negedge clk);

    // Random traffic on the 3-master instance: grant and data isolation.
    done_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      t3_valid = 3'($urandom_range(0, 7));
      t3_sr    = 1'($urandom_range(0, 1));
      t3_sdv   = 1'($urandom_range(0, 1));
      t3_mdr   = 3'($urandom_range(0, 7));
      t3_sdata = {$urandom, $urandom};
      #1;
      ok = ($countones(t3_grant) <= 1) && ((t3_mdv & ~t3_grant) == '0) &&
           ((t3_mrdy & ~t3_grant) == '0) && (t3_busy || (t3_grant == '0));
      for (int i = 0; i < 3; i++) begin
        if (!t3_grant[i] && (t3_mdata[i*DW +: DW] != '0)) ok = 1'b0;
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL iso_cycle_%0d: grant=%b mdv=%b mrdy=%b busy=%b; want one-hot-or-zero grant, no ungranted activity",
                 c, t3_grant, t3_mdv, t3_mrdy, t3_busy);
      end
      if (t3_sdv && t3_sdr) done_cnt++;
    end
    check("iso_completions_seen", 32'(done_cnt > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
